rst_seq: RTL
============

# rst_seq

Parametrised reset sequencer with a run-timeout monitor. After the global reset releases, it releases `NUM_DOM` downstream reset domains one at a time, `STAGE_CYC` cycles apart, and raises `seq_done` when the last domain is out of reset. It then counts a bounded run window and flags `timeout`. It sits at the SoC top, between the board reset and the per-domain resets (core, APB, UART, JTAG). It also serves as the synthesizable replacement for ad-hoc delay-and-finish sequencing in benches.

## Interface
Parameters:
- `NUM_DOM`, default 4: number of reset domains. Legal range 1..16.
- `STAGE_CYC`, default 8: cycles between successive domain releases. Must be ≥ 1.
- `RUN_CYC`, default 100: run-window length in cycles after `seq_done`. Must be ≥ 1.
- `CNT_W`, default 16: timer width. Must satisfy `2**CNT_W > max(STAGE_CYC, RUN_CYC)`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `soft_rst_req` in 1: level request to re-run the sequence.
- `dom_rst_n` out NUM_DOM: active-low domain resets; bit 0 is released first.
- `stage_idx` out $clog2(NUM_DOM+1): number of domains released so far.
- `seq_done` out 1: high once all domains are released.
- `timeout` out 1: sticky; high once the run window expires.

## Operation
- FSM states: HOLD, RELEASE, RUN, EXPIRED.
- Reset values (`reset`=1): state HOLD, `dom_rst_n`=all 0, `stage_idx`=0, `seq_done`=0, `timeout`=0, timer=0.
- HOLD: the first edge with `reset`=0 and `soft_rst_req`=0 moves the FSM to RELEASE with timer=1.
- RELEASE: the timer increments every cycle. When timer==`STAGE_CYC`:
  - set `dom_rst_n[stage_idx]`=1;
  - increment `stage_idx`;
  - reset timer to 1.
- Once `stage_idx` reaches `NUM_DOM`, the FSM moves to RUN on the same edge. `seq_done`=1 on that edge and the timer restarts at 1.
- RUN: the timer increments. On timer==`RUN_CYC` the FSM moves to EXPIRED and `timeout`=1.
- EXPIRED: terminal. All outputs hold until `reset` or `soft_rst_req`.
- `soft_rst_req`=1 sampled in any state: the next edge applies the full reset values and the FSM enters HOLD. While the request stays high, the FSM remains in HOLD.
- Priority: `reset` > `soft_rst_req` > normal sequencing.
- Released bits never re-assert except via `reset` or `soft_rst_req`; the release order is strictly ascending.
- Timer arithmetic is unsigned `CNT_W` bits and never wraps, given the legal parameters.

## Timing
- Edge numbering: edge 1 is the first rising edge sampling `reset`=0.
  - Edge 1: enter RELEASE.
  - `dom_rst_n[k]` rises at edge 1+(k+1)·`STAGE_CYC`.
  - `seq_done` rises at edge 1+`NUM_DOM`·`STAGE_CYC`.
  - `timeout` rises at edge 1+`NUM_DOM`·`STAGE_CYC`+`RUN_CYC`.
- All outputs are registered; there is no combinational path from any input to any output.
- `soft_rst_req` latency: outputs reach reset values one edge after the request is sampled. The sequence restarts exactly as after `reset`, with edge 1 being the first edge sampling the request low.
- Reset mid-operation: returns to HOLD on the next edge regardless of state.
- `STAGE_CYC`=1: one domain is released per cycle.
- `NUM_DOM`=1: `seq_done` and `dom_rst_n[0]` rise on the same edge.

## Configuration
- Macro `RST_SEQ_TIMEOUT_EN`.
- Defined: the RUN timer and EXPIRED state are present, and `timeout` behaves as above.
- Undefined: RUN is terminal, `timeout` is tied to 0, and the run timer logic is removed. Sequencing timing is unchanged.

## Structure
- Package `rst_seq_pkg`: state enum typedef `rst_seq_state_t` (HOLD, RELEASE, RUN, EXPIRED) and a width function for `stage_idx`.
- Sub-module `rst_seq_timer`: `CNT_W`-bit up-counter with synchronous clear-to-1 and a terminal-match output. A single instance is shared between the stage and run phases.
- Top module: FSM, release shift logic and output registers.

## Test plan
All scenarios use defaults `NUM_DOM`=4, `STAGE_CYC`=8, `RUN_CYC`=100.
- Reset held 5 cycles, then released → `dom_rst_n` = 0001, 0011, 0111, 1111 at edges 9, 17, 25, 33; `stage_idx` = 1..4; `seq_done`=1 at edge 33.
- Run continues after `seq_done` → `timeout`=1 at edge 133 and stays 1 for 50 further cycles.
- `soft_rst_req` pulsed for 3 cycles at edge 20 → `dom_rst_n`=0000 at edge 21. Restart from the first low-sampled edge E; first release at E+8.
- `reset` asserted at edge 28 during RELEASE → all outputs zero at edge 29. Full sequence repeats after release.
- `reset` and `soft_rst_req` both high, then only `reset` dropped → FSM stays in HOLD and outputs stay zero until the request drops.
- Built without `RST_SEQ_TIMEOUT_EN`, run for 500 cycles after `seq_done` → `timeout` stays 0.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Purpose : shared types and helpers for the reset sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: rst_seq_state_t FSM encoding, stage_w() width of the stage counter.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    EXPIRED = 2'd3
  } rst_seq_state_t;

  // Width needed to count 0..n released domains inclusive.
  function automatic int unsigned stage_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Purpose : bundle of control/status signals between the sequencer and its consumer.
// Latency : n/a (wires only).
// Backpressure: none; all signals are levels.
// Signals : soft_rst_req (consumer -> sequencer), dom_rst_n, stage_idx, seq_done,
//           timeout (sequencer -> consumer). master = sequencer side, slave = consumer.
interface rst_seq_if #(
  parameter int unsigned NUM_DOM = 4
);
  import rst_seq_pkg::*;

  localparam int unsigned SW = stage_w(NUM_DOM);

  logic               soft_rst_req;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic [SW-1:0]      stage_idx;
  logic               seq_done;
  logic               timeout;

  modport master (
    input  soft_rst_req,
    output dom_rst_n,
    output stage_idx,
    output seq_done,
    output timeout
  );

  modport slave (
    output soft_rst_req,
    input  dom_rst_n,
    input  stage_idx,
    input  seq_done,
    input  timeout
  );

endinterface

// File: rtl/rst_seq_timer.sv
// Purpose : CNT_W-bit up-counter with synchronous clear-to-1 and terminal-match flag.
// Latency : count updates on the edge after clr_i/inc_i; match_o is combinational on the count.
// Backpressure: none.
// Ports   : clk, rst_i (sync, to 0), clr_i (load 1, wins over inc_i), inc_i,
//           term_i (terminal value), match_o (count == term_i).
module rst_seq_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] term_i,
  output logic             match_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_W'(1);
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_o = (cnt_q == term_i);

endmodule

// File: rtl/rst_seq.sv
// Purpose : releases NUM_DOM reset domains STAGE_CYC apart, then times a RUN_CYC run window.
// Latency : all outputs registered; soft_rst_req/reset take effect on the next edge.
// Backpressure: none; soft_rst_req is a level that holds the sequencer in HOLD.
// Ports   : clk, reset (sync, active-high), bus (rst_seq_if.master).
// Config  : define RST_SEQ_TIMEOUT_EN to build the run timer and EXPIRED state;
//           otherwise RUN is terminal and timeout is tied low.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOM   = 4,
  parameter int unsigned STAGE_CYC = 8,
  parameter int unsigned RUN_CYC   = 100,
  parameter int unsigned CNT_W     = 16
) (
  input logic       clk,
  input logic       reset,
  rst_seq_if.master bus
);

  localparam int unsigned        SW         = stage_w(NUM_DOM);
  localparam logic [SW-1:0]      LAST_STAGE = SW'(NUM_DOM - 1);
  localparam logic [NUM_DOM-1:0] REL_LSB    = NUM_DOM'(1);
  localparam logic [CNT_W-1:0]   STAGE_TERM = CNT_W'(STAGE_CYC);
  localparam logic [CNT_W-1:0]   RUN_TERM   = CNT_W'(RUN_CYC);

  rst_seq_state_t state_q, state_d;

  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic [SW-1:0]      stage_q, stage_d;
  logic               done_q, done_d;
`ifdef RST_SEQ_TIMEOUT_EN
  logic               to_q, to_d;
`endif

  logic             soft_req;
  logic             tmr_rst;
  logic             tmr_clr;
  logic             tmr_inc;
  logic [CNT_W-1:0] tmr_term;
  logic             tmr_match;

  assign soft_req = bus.soft_rst_req;

  // A soft request zeroes the timer exactly like a hard reset.
  assign tmr_rst  = reset | soft_req;
  // One counter serves both phases; only the terminal value changes.
  assign tmr_term = (state_q == RUN) ? RUN_TERM : STAGE_TERM;

  rst_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_i   (tmr_rst),
    .clr_i   (tmr_clr),
    .inc_i   (tmr_inc),
    .term_i  (tmr_term),
    .match_o (tmr_match)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (soft_req) begin
      state_d = HOLD;
    end else begin
      case (state_q)
        HOLD:    state_d = RELEASE;
        RELEASE: begin
          // The last release and the move to RUN share one edge.
          if (tmr_match && (stage_q == LAST_STAGE)) begin
            state_d = RUN;
          end
        end
        RUN: begin
`ifdef RST_SEQ_TIMEOUT_EN
          if (tmr_match) begin
            state_d = EXPIRED;
          end
`endif
        end
        EXPIRED: state_d = EXPIRED;
        default: state_d = HOLD;
      endcase
    end
  end

  // Output / datapath next-values.
  always_comb begin
    dom_d   = dom_q;
    stage_d = stage_q;
    done_d  = done_q;
`ifdef RST_SEQ_TIMEOUT_EN
    to_d    = to_q;
`endif
    tmr_clr = 1'b0;
    tmr_inc = 1'b0;
    if (soft_req) begin
      dom_d   = '0;
      stage_d = '0;
      done_d  = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      to_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        HOLD: tmr_clr = 1'b1;
        RELEASE: begin
          if (tmr_match) begin
            // Shift a 1 in from bit 0 so releases are strictly ascending.
            dom_d   = (dom_q << 1) | REL_LSB;
            stage_d = stage_q + SW'(1);
            tmr_clr = 1'b1;
            if (stage_q == LAST_STAGE) begin
              done_d = 1'b1;
            end
          end else begin
            tmr_inc = 1'b1;
          end
        end
        RUN: begin
`ifdef RST_SEQ_TIMEOUT_EN
          if (tmr_match) begin
            to_d = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dom_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      dom_q   <= dom_d;
      stage_q <= stage_d;
      done_q  <= done_d;
`ifdef RST_SEQ_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign bus.dom_rst_n = dom_q;
  assign bus.stage_idx = stage_q;
  assign bus.seq_done  = done_q;
`ifdef RST_SEQ_TIMEOUT_EN
  assign bus.timeout   = to_q;
`else
  assign bus.timeout   = 1'b0;
`endif

endmodule
